// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - AES-128 round-key schedule sequencer with buffered read port and key stream
//
// Purpose: expands a 128-bit cipher key into round keys 0..NUM_ROUNDS, one round per
// clock, through a single shared func_g (RotWord/SubWord/Rcon) instance.
// Optional build macro: KEY_EXPAND_ZEROIZE_EN - when defined, an accepted start clears
// buffer entries 1..NUM_ROUNDS so no key material from the previous schedule survives.
//
// func_g ports:
//   w [0:31]        last word of the previous round key
//   i [0:IDX_W-1]   round number selecting Rcon (1..10)
//   g [0:31]        SubWord(RotWord(w)) ^ {Rcon(i), 24'h0}
//
// key_expand_seq ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   start                    one-cycle expansion request, honoured only in IDLE
//   key_in [0:127]           cipher key, big-endian bytes (word0 = key_in[0:31])
//   busy                     expansion in progress
//   keys_valid               buffer holds the complete schedule of the last key
//   rk_rd_idx [0:IDX_W-1]    round-key read index
//   rk_rd_data [0:127]       registered read data (0 for indices above NUM_ROUNDS)
//   str_vld/str_idx/str_key  one-cycle pulse per generated round key

module func_g #(
  parameter int IDX_W = 4
) (
  input  logic [0:31]      w,
  input  logic [0:IDX_W-1] i,
  output logic [0:31]      g
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, which maps 0 to 0) followed by
  // the AES affine transform; avoids a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] x12;
    logic [7:0] x15;
    logic [7:0] x240;
    logic [7:0] v;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    v    = gf_mul(gf_mul(x240, x12), x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    case (r)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // RotWord moves byte 0 to the end; Rcon lands on the first output byte.
  assign g = {sbox(w[8:15]) ^ rcon(int'(i)), sbox(w[16:23]), sbox(w[24:31]), sbox(w[0:7])};

endmodule

module key_expand_seq #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:127]     key_in,
  output logic             busy,
  output logic             keys_valid,
  input  logic [0:IDX_W-1] rk_rd_idx,
  output logic [0:127]     rk_rd_data,
  output logic             str_vld,
  output logic [0:IDX_W-1] str_idx,
  output logic [0:127]     str_key
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ctr_q, ctr_d;
  logic               busy_q, busy_d;
  logic               keys_valid_q, keys_valid_d;
  logic               str_vld_q, str_vld_d;
  logic [IDX_W-1:0]   str_idx_q, str_idx_d;
  logic [0:127]       str_key_q, str_key_d;
  logic [0:127]       rd_data_q, rd_data_d;
  logic [0:127]       rk_q [0:NUM_ROUNDS];
  logic [0:127]       rk_d [0:NUM_ROUNDS];

  logic [IDX_W-1:0]   prev_idx;
  logic [0:127]       prev_rk;
  logic [0:31]        g_out;
  logic [0:31]        w4, w5, w6, w7;
  logic [0:127]       new_rk;

  // ctr is only 0 in IDLE after reset; clamp so the buffer index stays in range.
  assign prev_idx = (ctr_q == '0) ? '0 : ctr_q - 1'b1;
  assign prev_rk  = rk_q[prev_idx];

  func_g #(.IDX_W(IDX_W)) u_func_g (
    .w (prev_rk[96:127]),
    .i (ctr_q),
    .g (g_out)
  );

  assign w4     = prev_rk[0:31]  ^ g_out;
  assign w5     = prev_rk[32:63] ^ w4;
  assign w6     = prev_rk[64:95] ^ w5;
  assign w7     = prev_rk[96:127] ^ w6;
  assign new_rk = {w4, w5, w6, w7};

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    busy_d       = busy_q;
    keys_valid_d = keys_valid_q;
    str_vld_d    = 1'b0;
    str_idx_d    = str_idx_q;
    str_key_d    = str_key_q;
    rk_d         = rk_q;
    rd_data_d    = (rk_rd_idx <= LAST) ? rk_q[rk_rd_idx] : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rk_d[0] = key_in;
`ifdef KEY_EXPAND_ZEROIZE_EN
          for (int k = 1; k <= NUM_ROUNDS; k++) rk_d[k] = '0;
`endif
          ctr_d        = IDX_W'(1);
          state_d      = S_EXPAND;
          busy_d       = 1'b1;
          keys_valid_d = 1'b0;
          str_vld_d    = 1'b1;
          str_idx_d    = '0;
          str_key_d    = key_in;
        end
      end
      S_EXPAND: begin
        rk_d[ctr_q] = new_rk;
        str_vld_d   = 1'b1;
        str_idx_d   = ctr_q;
        str_key_d   = new_rk;
        if (ctr_q == LAST) state_d = S_DONE;
        else               ctr_d   = ctr_q + 1'b1;
      end
      S_DONE: begin
        busy_d       = 1'b0;
        keys_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      str_vld_q    <= 1'b0;
      str_idx_q    <= '0;
      str_key_q    <= '0;
      rd_data_q    <= '0;
      for (int k = 0; k <= NUM_ROUNDS; k++) rk_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      busy_q       <= busy_d;
      keys_valid_q <= keys_valid_d;
      str_vld_q    <= str_vld_d;
      str_idx_q    <= str_idx_d;
      str_key_q    <= str_key_d;
      rd_data_q    <= rd_data_d;
      rk_q         <= rk_d;
    end
  end

  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign str_vld    = str_vld_q;
  assign str_idx    = str_idx_q;
  assign str_key    = str_key_q;
  assign rk_rd_data = rd_data_q;

endmodule
